snake_body_tracker: RTL

Owns one snake's position state and produces what the collision detector consumes: the body occupancy bitmap, the head coordinates and the grace-period flag. It advances the snake one cell per move tick in the commanded direction and grows it on food events. A ring buffer of segment coordinates drives incremental bitmap updates. One instance per snake; its dead input comes back from the collision detector.

---
 rtl/snake_body_tracker.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/snake_body_tracker.sv
// Snake position tracker: ring buffer of segments driving an incremental occupancy bitmap.
// Build option: define SNAKE_WRAP_EN for toroidal edges; otherwise leaving the grid is fatal.
module snake_body_tracker #(
    parameter int WIDTH       = 32,
    parameter int HEIGHT      = 32,
    parameter int MAX_LEN     = 64,
    parameter int INIT_LEN    = 3,
    parameter int START_X     = 16,
    parameter int START_Y     = 16,
    parameter int GRACE_TICKS = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          tick,
    input  logic [1:0]                    dir_in,
    input  logic                          grow,
    input  logic                          dead,
    output logic [WIDTH-1:0][HEIGHT-1:0]  body,
    output logic [6:0]                    headx,
    output logic [6:0]                    heady,
    output logic                          gracePeriod,
    output logic [6:0]                    length,
    output logic                          wall_hit
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int GW = $clog2(GRACE_TICKS + 1);
    localparam logic [6:0] X_MAX = 7'(WIDTH - 1);
    localparam logic [6:0] Y_MAX = 7'(HEIGHT - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GRACE, S_RUN, S_DEAD} state_t;

    state_t                        state_q, state_d;
    logic [WIDTH-1:0][HEIGHT-1:0]  body_q, body_d;
    logic [6:0]                    head_x_q, head_x_d, head_y_q, head_y_d;
    logic [6:0]                    len_q, len_d;
    logic                          wall_q, wall_d;
    logic [1:0]                    dir_q, dir_d;
    logic                          pend_q, pend_d;
    logic [GW-1:0]                 gcnt_q, gcnt_d;
    logic [AW-1:0]                 head_ptr_q, head_ptr_d, tail_ptr_q, tail_ptr_d;

    // Segment ring: head_ptr is the newest entry, tail_ptr the oldest
    logic [6:0]    seg_x_q [MAX_LEN];
    logic [6:0]    seg_y_q [MAX_LEN];
    logic          wr_en;
    logic [AW-1:0] wr_ptr;
    logic [6:0]    wr_x, wr_y;

    logic [6:0] tail_x, tail_y, load_x, nx, ny;
    logic [1:0] mv_dir;
    logic       rev, blocked, do_grow;

    always_comb begin
        tail_x = seg_x_q[tail_ptr_q];
        tail_y = seg_y_q[tail_ptr_q];
        load_x = (tail_x == 7'd0) ? X_MAX : tail_x - 7'd1;

        rev    = (dir_in[1] == dir_q[1]) && (dir_in[0] != dir_q[0]);
        mv_dir = rev ? dir_q : dir_in;
        nx     = head_x_q;
        ny     = head_y_q;
        case (mv_dir)
            2'b00:   nx = (head_x_q == X_MAX) ? 7'd0 : head_x_q + 7'd1;
            2'b01:   nx = (head_x_q == 7'd0) ? X_MAX : head_x_q - 7'd1;
            2'b10:   ny = (head_y_q == 7'd0) ? Y_MAX : head_y_q - 7'd1;
            default: ny = (head_y_q == Y_MAX) ? 7'd0 : head_y_q + 7'd1;
        endcase
`ifdef SNAKE_WRAP_EN
        blocked = 1'b0;
`else
        blocked = (mv_dir == 2'b00 && head_x_q == X_MAX) ||
                  (mv_dir == 2'b01 && head_x_q == 7'd0)  ||
                  (mv_dir == 2'b10 && head_y_q == 7'd0)  ||
                  (mv_dir == 2'b11 && head_y_q == Y_MAX);
`endif
        do_grow = (pend_q || grow) && (len_q < 7'(MAX_LEN));
    end

    always_comb begin
        state_d    = state_q;
        body_d     = body_q;
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        len_d      = len_q;
        wall_d     = wall_q;
        dir_d      = dir_q;
        pend_d     = pend_q;
        gcnt_d     = gcnt_q;
        head_ptr_d = head_ptr_q;
        tail_ptr_d = tail_ptr_q;
        wr_en      = 1'b0;
        wr_ptr     = head_ptr_q;
        wr_x       = head_x_q;
        wr_y       = head_y_q;

        case (state_q)
            S_LOAD: begin
                // Each load cycle appends one segment one cell further -x behind the tail
                wr_en      = 1'b1;
                wr_ptr     = tail_ptr_q - AW'(1);
                wr_x       = load_x;
                wr_y       = tail_y;
                tail_ptr_d = tail_ptr_q - AW'(1);
                body_d[load_x[XW-1:0]][tail_y[YW-1:0]] = 1'b1;
                len_d      = len_q + 7'd1;
                if (len_q + 7'd1 == 7'(INIT_LEN))
                    state_d = S_GRACE;
            end
            S_GRACE, S_RUN: begin
                if (tick) begin
                    if (blocked) begin
                        wall_d  = 1'b1;
                        state_d = S_DEAD;
                    end else begin
                        dir_d      = mv_dir;
                        head_x_d   = nx;
                        head_y_d   = ny;
                        head_ptr_d = head_ptr_q + AW'(1);
                        wr_en      = 1'b1;
                        wr_ptr     = head_ptr_q + AW'(1);
                        wr_x       = nx;
                        wr_y       = ny;
                        pend_d     = 1'b0;
                        body_d[head_x_q[XW-1:0]][head_y_q[YW-1:0]] = 1'b1;
                        // Tail clear is applied after the set so it wins on a shared cell
                        if (do_grow) begin
                            len_d = len_q + 7'd1;
                        end else begin
                            body_d[tail_x[XW-1:0]][tail_y[YW-1:0]] = 1'b0;
                            tail_ptr_d = tail_ptr_q + AW'(1);
                        end
                        if (state_q == S_GRACE) begin
                            gcnt_d = gcnt_q - GW'(1);
                            if (gcnt_q == GW'(1))
                                state_d = S_RUN;
                        end else if (dead) begin
                            state_d = S_DEAD;
                        end
                    end
                end else begin
                    if (grow)
                        pend_d = 1'b1;
                    if (state_q == S_RUN && dead)
                        state_d = S_DEAD;
                end
            end
            default: ;
        endcase

        if (start && state_q != S_LOAD) begin
            state_d    = S_LOAD;
            body_d     = '0;
            head_x_d   = 7'(START_X);
            head_y_d   = 7'(START_Y);
            len_d      = 7'd1;
            wall_d     = 1'b0;
            dir_d      = 2'b00;
            pend_d     = 1'b0;
            gcnt_d     = GW'(GRACE_TICKS);
            head_ptr_d = '0;
            tail_ptr_d = '0;
            wr_en      = 1'b1;
            wr_ptr     = '0;
            wr_x       = 7'(START_X);
            wr_y       = 7'(START_Y);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            body_q     <= '0;
            head_x_q   <= 7'(START_X);
            head_y_q   <= 7'(START_Y);
            len_q      <= 7'd0;
            wall_q     <= 1'b0;
            dir_q      <= 2'b00;
            pend_q     <= 1'b0;
            gcnt_q     <= '0;
            head_ptr_q <= '0;
            tail_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            body_q     <= body_d;
            head_x_q   <= head_x_d;
            head_y_q   <= head_y_d;
            len_q      <= len_d;
            wall_q     <= wall_d;
            dir_q      <= dir_d;
            pend_q     <= pend_d;
            gcnt_q     <= gcnt_d;
            head_ptr_q <= head_ptr_d;
            tail_ptr_q <= tail_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            seg_x_q[wr_ptr] <= wr_x;
            seg_y_q[wr_ptr] <= wr_y;
        end
    end

    assign body        = body_q;
    assign headx       = head_x_q;
    assign heady       = head_y_q;
    assign length      = len_q;
    assign wall_hit    = wall_q;
    assign gracePeriod = (state_q == S_LOAD) || (state_q == S_GRACE);

endmodule
